// File: rtl/conveyor_load_unit_if.sv
// Issue, memory and conveyor-write channels of the conveyor load unit.
// The slave modport is the load unit's view; the master modport is its environment.
interface conveyor_load_unit_if #(
    parameter int WORD_WIDTH          = 32,
    parameter int CONVEYOR_ADDR_WIDTH = 4
);
    logic                           issue_valid;
    logic                           issue_ready;
    logic [WORD_WIDTH-1:0]          issue_addr;
    logic                           issue_conveyor;
    logic [CONVEYOR_ADDR_WIDTH-1:0] issue_slot;

    logic                           mem_req;
    logic [WORD_WIDTH-1:0]          mem_addr;
    logic                           mem_ack;
    logic [WORD_WIDTH-1:0]          mem_data;
    logic [2:0]                     mem_fault;

    logic                           wr_valid;
    logic                           wr_conveyor;
    logic [CONVEYOR_ADDR_WIDTH-1:0] wr_slot;
    logic [2:0]                     wr_fault;
    logic [WORD_WIDTH-1:0]          wr_value;

    modport slave (
        input  issue_valid, issue_addr, issue_conveyor, issue_slot,
        output issue_ready,
        output mem_req, mem_addr,
        input  mem_ack, mem_data, mem_fault,
        output wr_valid, wr_conveyor, wr_slot, wr_fault, wr_value
    );

    modport master (
        output issue_valid, issue_addr, issue_conveyor, issue_slot,
        input  issue_ready,
        input  mem_req, mem_addr,
        output mem_ack, mem_data, mem_fault,
        input  wr_valid, wr_conveyor, wr_slot, wr_fault, wr_value
    );
endinterface

// File: rtl/conveyor_load_unit.sv
// In-order load queue feeding a single-outstanding memory read; each load
// produces one {finished, fault, value} write into the destination conveyor slot.
module conveyor_load_unit #(
    parameter int         WORD_WIDTH          = 32,
    parameter int         CONVEYOR_ADDR_WIDTH = 4,
    parameter int         QUEUE_DEPTH         = 4,
    parameter int         MEM_WORDS           = 65536,
    parameter logic [2:0] FAULT_RANGE         = 3'd2
) (
    input logic                 clk,
    input logic                 reset,
    conveyor_load_unit_if.slave bus
);
    localparam logic [2:0]            F_NONE     = 3'd0;
    localparam int                    PTR_W      = $clog2(QUEUE_DEPTH);
    localparam logic [PTR_W:0]        DEPTH_C    = (PTR_W + 1)'(QUEUE_DEPTH);
    localparam logic [WORD_WIDTH:0]   ADDR_LIMIT = (WORD_WIDTH + 1)'(MEM_WORDS);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t                         state;
    state_t                         state_nxt;

    logic [WORD_WIDTH-1:0]          q_addr     [QUEUE_DEPTH];
    logic                           q_conveyor [QUEUE_DEPTH];
    logic [CONVEYOR_ADDR_WIDTH-1:0] q_slot     [QUEUE_DEPTH];
    logic [PTR_W-1:0]               wr_ptr;
    logic [PTR_W-1:0]               rd_ptr;
    logic [PTR_W:0]                 count;

    logic [WORD_WIDTH-1:0]          head_addr;
    logic                           head_conveyor;
    logic [CONVEYOR_ADDR_WIDTH-1:0] head_slot;

    logic                           push;
    logic                           pop;
    logic                           load_wr;
    logic [2:0]                     load_fault;
    logic [WORD_WIDTH-1:0]          load_value;

    logic                           wr_conveyor_r;
    logic [CONVEYOR_ADDR_WIDTH-1:0] wr_slot_r;
    logic [2:0]                     wr_fault_r;
    logic [WORD_WIDTH-1:0]          wr_value_r;

    function automatic logic addr_in_range(input logic [WORD_WIDTH-1:0] a);
        return {1'b0, a} < ADDR_LIMIT;
    endfunction

    // A faulted slot must never expose memory data to the conveyor.
    function automatic logic [WORD_WIDTH-1:0] mask_faulted(input logic [WORD_WIDTH-1:0] v,
                                                           input logic [2:0]            f);
        return (f == F_NONE) ? v : '0;
    endfunction

    // Stage: issue queue
    assign push            = bus.issue_valid && bus.issue_ready;
    assign bus.issue_ready = (count < DEPTH_C);

    assign head_addr     = q_addr[rd_ptr];
    assign head_conveyor = q_conveyor[rd_ptr];
    assign head_slot     = q_slot[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr]     <= bus.issue_addr;
            q_conveyor[wr_ptr] <= bus.issue_conveyor;
            q_slot[wr_ptr]     <= bus.issue_slot;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Stage: memory handshake control
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        pop        = 1'b0;
        load_wr    = 1'b0;
        load_fault = F_NONE;
        load_value = '0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    if (!addr_in_range(head_addr)) begin
                        pop        = 1'b1;
                        load_wr    = 1'b1;
                        load_fault = FAULT_RANGE;
                        state_nxt  = RESP;
                    end else begin
                        state_nxt  = REQ;
                    end
                end
            end
            REQ: begin
                if (bus.mem_ack) begin
                    pop        = 1'b1;
                    load_wr    = 1'b1;
                    load_fault = bus.mem_fault;
                    load_value = mask_faulted(bus.mem_data, bus.mem_fault);
                    state_nxt  = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // The head entry is not popped until the ack, so the address holds for the whole request.
    assign bus.mem_req  = (state == REQ);
    assign bus.mem_addr = head_addr;

    // Stage: conveyor write
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_conveyor_r <= 1'b0;
            wr_slot_r     <= '0;
            wr_fault_r    <= F_NONE;
            wr_value_r    <= '0;
        end else if (load_wr) begin
            wr_conveyor_r <= head_conveyor;
            wr_slot_r     <= head_slot;
            wr_fault_r    <= load_fault;
            wr_value_r    <= load_value;
        end
    end

    assign bus.wr_valid    = (state == RESP);
    assign bus.wr_conveyor = wr_conveyor_r;
    assign bus.wr_slot     = wr_slot_r;
    assign bus.wr_fault    = wr_fault_r;
    assign bus.wr_value    = wr_value_r;
endmodule

// File: doc/conveyor_load_unit.md
Name: conveyor_load_unit

Overview:
- Asynchronous memory-load stage sitting directly upstream of the conveyor write port.
- The decode stage issues loads tagged with a destination conveyor (normal or interrupt) and slot (typically conveyor_back1/back2).
- The unit queues the loads in order and performs them over a single-outstanding memory handshake.
- It returns one write per load, carrying {finished=1, fault, value}; the conveyor marks that slot finished so I_CVZ-class reads stop halting.

Parameters:
- WORD_WIDTH, 32, data and address width.
- CONVEYOR_ADDR_WIDTH, 4, conveyor slot index width.
- QUEUE_DEPTH, 4, outstanding-load queue entries; power of two, 2 or more.
- MEM_WORDS, 65536, valid address range is 0 to MEM_WORDS-1.
- FAULT_RANGE, 3'd2, fault code for an out-of-range address.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- issue_valid  in  1  load request present.
- issue_ready  out  1  queue can accept a request.
- issue_addr  in  WORD_WIDTH  word address to load.
- issue_conveyor  in  1  destination conveyor: 0 = normal, 1 = interrupt.
- issue_slot  in  CONVEYOR_ADDR_WIDTH  destination slot.
- mem_req  out  1  memory read request.
- mem_addr  out  WORD_WIDTH  read address.
- mem_ack  in  1  read completes this cycle.
- mem_data  in  WORD_WIDTH  read data, valid with mem_ack.
- mem_fault  in  3  fault code, valid with mem_ack; `F_NONE` when the read is good.
- wr_valid  out  1  one-cycle conveyor write strobe.
- wr_conveyor  out  1  destination conveyor.
- wr_slot  out  CONVEYOR_ADDR_WIDTH  destination slot.
- wr_fault  out  3  fault code for the slot.
- wr_value  out  WORD_WIDTH  loaded value; 0 when faulted.

Behaviour:
- Clocking and reset: one clock, clk. reset is synchronous and active-high.
- Reset values:
  - Queue count = 0, state = IDLE.
  - mem_req = 0, wr_valid = 0.
  - wr_* = 0, except wr_fault = `F_NONE`.
  - issue_ready = 1 in the cycle after reset deasserts.
- Reset mid-operation:
  - Discards all queued and in-flight loads.
  - mem_req drops on the next cycle.
  - A later mem_ack from the dropped transaction is ignored.
- Queue:
  - In-order FIFO of {addr, conveyor, slot}.
  - Accept on the edge where issue_valid && issue_ready.
  - issue_ready = (count < QUEUE_DEPTH); it is registered-count based, with no same-cycle bypass of a pop.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo QUEUE_DEPTH.
- FSM states: IDLE, REQ, RESP.
  - IDLE, queue empty: stay in IDLE.
  - IDLE, head addr >= MEM_WORDS:
    - Pop the head.
    - Load wr_* with {head conveyor, head slot, FAULT_RANGE, 0}.
    - Go to RESP. No memory access is made.
  - IDLE, otherwise: go to REQ.
  - REQ:
    - mem_req = 1, mem_addr = head addr; both are held stable until mem_ack.
    - On mem_ack: pop the head, register {conveyor, slot, mem_fault, data}, go to RESP.
    - If mem_fault != `F_NONE`, wr_value = 0.
  - RESP: wr_valid = 1 for exactly one cycle, then go to IDLE.
- Decoded from state: mem_req and wr_valid; wr_* are registers.
- Latency:
  - Issue accepted at edge E0; REQ from E1.
  - mem_ack sampled at edge Ek (k ≥ 2) gives wr_valid in the cycle after Ek.
  - Minimum issue-to-write latency is 3 cycles; a range fault takes 2 cycles.
- Ordering and throughput:
  - Writes leave in issue order.
  - At most one memory transaction is outstanding.
  - At most one write per 2 cycles.
- mem_ack outside REQ is ignored.
- Slot reuse: the unit does not check slot aliasing. Two queued loads to the same slot produce two writes in order, and the last write wins.

Test Plan:
- Single load:
  - Stimulus: reset, then issue addr=0x10, conveyor=0, slot=5; memory acks on the first REQ cycle with data 0xDEADBEEF and fault `F_NONE`.
  - Required: mem_req lasts 1 cycle with mem_addr=0x10; wr_valid pulses 3 cycles after issue with slot=5, conveyor=0, value=0xDEADBEEF, fault=`F_NONE`.
- Back-pressure:
  - Stimulus: issue 5 loads with mem_ack held low and QUEUE_DEPTH=4.
  - Required: issue_ready=0 after 4 accepts. After 4 acks (data 1,2,3,4), writes occur in order with values 1,2,3,4 and their slots; the 5th load is accepted once an entry frees.
- Range fault:
  - Stimulus: issue addr=MEM_WORDS, slot=3, conveyor=1.
  - Required: mem_req never asserts; wr_valid 2 cycles after issue with fault=FAULT_RANGE, value=0, conveyor=1, slot=3.
- Memory fault:
  - Stimulus: memory acks with mem_fault=3'd1 and data 0x1234.
  - Required: wr_fault=1, wr_value=0.
- Ack delay and stability:
  - Stimulus: mem_ack delayed 6 cycles.
  - Required: mem_addr stays constant and mem_req stays high all 6 cycles; no spurious wr_valid.
- Reset mid-flight:
  - Stimulus: 2 loads queued, assert reset during REQ, then pulse mem_ack after reset releases.
  - Required: no wr_valid ever; count=0 and issue_ready=1 after reset.
